wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and architectural register file for the 5-stage pipeline. It consumes the MEM/WB pipeline register outputs, selects the writeback data, and commits it to a 32×32 register file. It also serves the two ID-stage read ports with same-cycle write-through bypass. It keeps 64-bit cycle and retired-instruction counters for debug and performance measurement.

## Interface
Parameters:
- XLEN, 32, data width of registers and writeback operands
- CNT_W, 64, width of the cycle and instret counters

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- wb_inst  input  32  instruction in WB; rd = wb_inst[11:7]; 32'b0 is a bubble
- wb_RF_WE  input  1  register write enable
- wb_wD_sel  input  2  writeback source select
- wb_alu_result  input  XLEN  ALU result
- wb_DRAM_rd  input  XLEN  load data
- wb_pc4  input  XLEN  PC+4 (jal/jalr link)
- id_rs1  input  5  read address, port 1
- id_rs2  input  5  read address, port 2
- rD1  output  XLEN  read data, port 1 (combinational)
- rD2  output  XLEN  read data, port 2 (combinational)
- wb_wD  output  XLEN  selected writeback data (combinational, for forwarding)
- wb_rd  output  5  destination register of the WB instruction (combinational)
- cycle_cnt  output  CNT_W  cycles since reset release
- instret_cnt  output  CNT_W  retired (non-bubble) instructions

## Operation
- Writeback mux: wD_sel 2'b00 → alu_result; 2'b01 → DRAM_rd; 2'b10 → pc4; 2'b11 is reserved and decodes as 2'b00.
- Commit: on a rising edge with wb_RF_WE=1 and wb_rd≠0, regs[wb_rd] ← wb_wD. Writes to x0 are discarded.
- Read: rDn = 0 when id_rsn=0. Otherwise, rDn = wb_wD when wb_RF_WE=1 and id_rsn==wb_rd (write-through bypass, so there is no WB→ID hazard). Otherwise rDn = regs[id_rsn].
- Both ports may read the same register. Both may also hit the bypass at the same time.
- cycle_cnt increments by 1 every clock after reset is released.
- instret_cnt increments by 1 on each edge where wb_inst≠32'b0, independent of wb_RF_WE. Stores and branches therefore count as retired.
- Both counters wrap modulo 2^CNT_W: all-ones → 0, with no saturation and no flag.

## Timing
- Reset (asynchronous assert, synchronous release via the system reset tree): all 31 registers, cycle_cnt and instret_cnt go to 0 immediately.
  - The combinational outputs follow their inputs during reset.
  - Writes are blocked while rst_n=0.
- Asserting reset in the middle of a write drops the write. The register reads 0 afterwards.
- Write latency: data is visible in regs one edge after presentation. It is visible on rD1/rD2 in the same cycle through the bypass.
- Reads have zero latency. The path from id_rs to rD is purely combinational.
- Read and write to the same register in the same cycle return the new value, not the old one.
- Counters change on the same edge that samples wb_inst, so instret_cnt reflects instructions retired up to and including the prior edge.

## Structure
- The shared package holds:
  - WD_SEL_ALU=2'b00, WD_SEL_DRAM=2'b01, WD_SEL_PC4=2'b10
  - RD_LSB=7, RD_MSB=11
  - BUBBLE=32'b0
- One sub-module, rf_array: 31×XLEN flop array with one write port and two asynchronous read ports, x0 excluded.
- The writeback mux, bypass compare and counters live in the wb_regfile top.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then read every register → rD1/rD2 = 0 and both counters = 0.
- Write then read:
  - Stimulus: inst=32'h00500093 (rd=x1), RF_WE=1, sel=00, alu=32'h1234, id_rs1=1 in the same cycle.
  - Response: rD1=32'h1234 in that cycle (bypass) and on the following cycle from the array.
- x0 guard: RF_WE=1, rd=0, alu=32'hFFFF → rD1 with id_rs1=0 reads 0 in both the same cycle and the next.
- Source select:
  - Stimulus: rd=x5, run sel=01 (DRAM=32'hA5A5), then sel=10 (pc4=32'h104), then sel=11 (alu=7).
  - Response: x5 holds A5A5, then 104, then 7.
- Counters:
  - Stimulus: 10 cycles with wb_inst = valid, BUBBLE, valid, valid, BUBBLE×6.
  - Response: cycle_cnt=10, instret_cnt=3.
  - Wrap: force cycle_cnt to all-ones → it reads 0 one edge later.
- Reset mid-write: assert rst_n low while presenting a write to x3 → x3 = 0 after release and the counters restart from 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback stage and register file.
// Writeback source encodings, rd field location and bubble encoding.
package wb_regfile_pkg;

    localparam logic [1:0] WD_SEL_ALU  = 2'b00;
    localparam logic [1:0] WD_SEL_DRAM = 2'b01;
    localparam logic [1:0] WD_SEL_PC4  = 2'b10;

    localparam int RD_LSB = 7;
    localparam int RD_MSB = 11;

    localparam logic [31:0] BUBBLE = 32'b0;

    function automatic logic [4:0] inst_rd(input logic [31:0] inst);
        return inst[RD_MSB:RD_LSB];
    endfunction

endpackage

// File: rtl/wb_regfile_rf.sv
// 31-entry register array, x0 has no storage and always reads zero.
// One synchronous write port, two asynchronous read ports.
module rf_array
    import wb_regfile_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [1:31];

    // Commit one register per edge; async reset clears the whole array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (we && waddr == 5'(i)) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Asynchronous reads, x0 forced to zero.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != 5'd0) begin
            rdata1 = regs[raddr1];
        end
        if (raddr2 != 5'd0) begin
            rdata2 = regs[raddr2];
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: source mux, register commit with write-through
// bypass to the ID read ports, and cycle/instret counters.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      wb_inst,
    input  logic             wb_RF_WE,
    input  logic [1:0]       wb_wD_sel,
    input  logic [XLEN-1:0]  wb_alu_result,
    input  logic [XLEN-1:0]  wb_DRAM_rd,
    input  logic [XLEN-1:0]  wb_pc4,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    output logic [XLEN-1:0]  rD1,
    output logic [XLEN-1:0]  rD2,
    output logic [XLEN-1:0]  wb_wD,
    output logic [4:0]       wb_rd,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    logic [XLEN-1:0] arr_rd1;
    logic [XLEN-1:0] arr_rd2;
    logic            commit;

    assign wb_rd  = inst_rd(wb_inst);
    assign commit = wb_RF_WE && (wb_rd != 5'd0);

    // Writeback source select; the reserved code falls back to ALU.
    always_comb begin
        case (wb_wD_sel)
            WD_SEL_DRAM: wb_wD = wb_DRAM_rd;
            WD_SEL_PC4:  wb_wD = wb_pc4;
            default:     wb_wD = wb_alu_result;
        endcase
    end

    rf_array #(
        .XLEN(XLEN)
    ) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (commit),
        .waddr (wb_rd),
        .wdata (wb_wD),
        .raddr1(id_rs1),
        .raddr2(id_rs2),
        .rdata1(arr_rd1),
        .rdata2(arr_rd2)
    );

    // Read ports: x0 is zero, same-cycle writes bypass the array.
    always_comb begin
        rD1 = arr_rd1;
        rD2 = arr_rd2;
        if (id_rs1 == 5'd0) begin
            rD1 = '0;
        end else if (wb_RF_WE && id_rs1 == wb_rd) begin
            rD1 = wb_wD;
        end
        if (id_rs2 == 5'd0) begin
            rD2 = '0;
        end else if (wb_RF_WE && id_rs2 == wb_rd) begin
            rD2 = wb_wD;
        end
    end

    // Free-running counters; both wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (wb_inst != BUBBLE) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: driver pushes expected outputs,
// negedge monitor pops and compares. A 4-bit-counter copy checks wrap.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wb_inst = '0;
    logic        wb_RF_WE = 1'b0;
    logic [1:0]  wb_wD_sel = '0;
    logic [31:0] wb_alu_result = '0;
    logic [31:0] wb_DRAM_rd = '0;
    logic [31:0] wb_pc4 = '0;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;

    logic [31:0] rD1, rD2, wb_wD;
    logic [4:0]  wb_rd;
    logic [63:0] cycle_cnt, instret_cnt;
    logic [31:0] s_rD1, s_rD2, s_wD;
    logic [4:0]  s_rd;
    logic [3:0]  s_cyc, s_ins;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst_n(rst_n), .wb_inst(wb_inst),
        .wb_RF_WE(wb_RF_WE), .wb_wD_sel(wb_wD_sel),
        .wb_alu_result(wb_alu_result), .wb_DRAM_rd(wb_DRAM_rd),
        .wb_pc4(wb_pc4), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .rD1(rD1), .rD2(rD2), .wb_wD(wb_wD), .wb_rd(wb_rd),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    wb_regfile #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .wb_inst(wb_inst),
        .wb_RF_WE(wb_RF_WE), .wb_wD_sel(wb_wD_sel),
        .wb_alu_result(wb_alu_result), .wb_DRAM_rd(wb_DRAM_rd),
        .wb_pc4(wb_pc4), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .rD1(s_rD1), .rD2(s_rD2), .wb_wD(s_wD), .wb_rd(s_rd),
        .cycle_cnt(s_cyc), .instret_cnt(s_ins)
    );

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [63:0] cyc;
        logic [63:0] ins;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors = 0;
    bit   done = 1'b0;

    logic [31:0] m_regs [32];
    logic [63:0] m_cyc;
    logic [63:0] m_ins;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per cycle, away from the clock edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            chk("rD1", 64'(rD1), 64'(e.rd1));
            chk("rD2", 64'(rD2), 64'(e.rd2));
            chk("wb_wD", 64'(wb_wD), 64'(e.wd));
            chk("wb_rd", 64'(wb_rd), 64'(e.rd));
            chk("cycle_cnt", cycle_cnt, e.cyc);
            chk("instret_cnt", instret_cnt, e.ins);
            chk("rD1_w4", 64'(s_rD1), 64'(e.rd1));
            chk("rD2_w4", 64'(s_rD2), 64'(e.rd2));
            chk("wD_w4", 64'(s_wD), 64'(e.wd));
            chk("rd_w4", 64'(s_rd), 64'(e.rd));
            chk("cycle_cnt_w4", 64'(s_cyc), 64'(e.cyc[3:0]));
            chk("instret_cnt_w4", 64'(s_ins), 64'(e.ins[3:0]));
        end
    end

    function automatic logic [31:0] m_wd(input logic [1:0] sel,
        input logic [31:0] alu, input logic [31:0] dram,
        input logic [31:0] pc4);
        if (sel == 2'd1) return dram;
        if (sel == 2'd2) return pc4;
        return alu;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] rs,
        input logic we, input logic [4:0] rd, input logic [31:0] wd);
        if (rs == 5'd0) return 32'd0;
        if (we && rs == rd) return wd;
        return m_regs[rs];
    endfunction

    // Called just after a rising edge: apply inputs, predict, advance.
    task automatic step(input logic rst, input logic [31:0] inst,
        input logic we, input logic [1:0] sel, input logic [31:0] alu,
        input logic [31:0] dram, input logic [31:0] pc4,
        input logic [4:0] rs1, input logic [4:0] rs2);
        exp_t e;
        logic [4:0]  rd;
        logic [31:0] wd;
        rst_n = rst;
        wb_inst = inst;
        wb_RF_WE = we;
        wb_wD_sel = sel;
        wb_alu_result = alu;
        wb_DRAM_rd = dram;
        wb_pc4 = pc4;
        id_rs1 = rs1;
        id_rs2 = rs2;
        if (!rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_cyc = '0;
            m_ins = '0;
        end
        rd = inst[11:7];
        wd = m_wd(sel, alu, dram, pc4);
        e.rd1 = m_read(rs1, we, rd, wd);
        e.rd2 = m_read(rs2, we, rd, wd);
        e.wd = wd;
        e.rd = rd;
        e.cyc = m_cyc;
        e.ins = m_ins;
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            if (we && rd != 5'd0) m_regs[rd] = wd;
            m_cyc = m_cyc + 64'd1;
            if (inst != 32'd0) m_ins = m_ins + 64'd1;
        end
        #1;
    endtask

    task automatic rd_only(input logic [4:0] rs1, input logic [4:0] rs2);
        step(1'b1, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, rs1, rs2);
    endtask

    initial begin
        logic [31:0] inst;
        foreach (m_regs[i]) m_regs[i] = '0;
        m_cyc = '0;
        m_ins = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0,
                 5'(i), 5'(i + 1));
        end
        for (int i = 0; i < 32; i++) begin
            rd_only(5'(i), 5'(31 - i));
        end
        step(1'b1, 32'h00500093, 1'b1, 2'd0, 32'h1234, 32'd0, 32'd0,
             5'd1, 5'd1);
        rd_only(5'd1, 5'd0);
        step(1'b1, 32'h00000013, 1'b1, 2'd0, 32'hFFFF, 32'd0, 32'd0,
             5'd0, 5'd0);
        rd_only(5'd0, 5'd1);
        step(1'b1, 32'h00000293, 1'b1, 2'd1, 32'd9, 32'hA5A5, 32'h104,
             5'd5, 5'd0);
        rd_only(5'd5, 5'd5);
        step(1'b1, 32'h00000293, 1'b1, 2'd2, 32'd9, 32'hA5A5, 32'h104,
             5'd0, 5'd5);
        rd_only(5'd5, 5'd1);
        step(1'b1, 32'h00000293, 1'b1, 2'd3, 32'd7, 32'hA5A5, 32'h104,
             5'd5, 5'd5);
        rd_only(5'd5, 5'd0);
        step(1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        for (int i = 0; i < 10; i++) begin
            inst = (i == 0 || i == 2 || i == 3) ? 32'h00000033 : 32'd0;
            step(1'b1, inst, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        end
        for (int i = 0; i < 20; i++) rd_only(5'd1, 5'd5);
        step(1'b1, 32'h000001B3, 1'b1, 2'd0, 32'hBEEF, 32'd0, 32'd0,
             5'd3, 5'd0);
        rd_only(5'd3, 5'd0);
        step(1'b0, 32'h000001B3, 1'b1, 2'd0, 32'hDEAD, 32'd0, 32'd0,
             5'd3, 5'd1);
        rd_only(5'd3, 5'd1);
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rd, rs1, rs2;
            rd = 5'($urandom_range(0, 31));
            rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            inst = $urandom;
            inst[11:7] = rd;
            if ($urandom_range(0, 4) == 0) inst = 32'd0;
            step(($urandom_range(0, 99) != 0), inst,
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 $urandom, $urandom, $urandom, rs1, rs2);
        end
        repeat (3) @(posedge clk);
        done = 1'b1;
    end

    initial begin
        fork
            wait (done);
            #200000;
        join_any
        if (!done) begin
            errors++;
            $display("FAIL timeout: done=%0d expected 1", done);
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
